// File: rtl/branch_predict_fetch.sv
// Fetch-PC generator with a direct-mapped branch target buffer.
// Each BTB entry holds a valid bit, a tag, a taken target and a 2-bit
// saturating direction counter. The lookup for the current PC is
// combinational. Updates from the EX stage are written on the clock edge,
// so a lookup in the same cycle still sees the old contents.
module branch_predict_fetch #(
    parameter int          ENTRIES  = 16,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PC_Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    input  logic        UpdValid,
    input  logic [31:0] UpdPC,
    input  logic        UpdTaken,
    input  logic [31:0] UpdTarget,
    output logic [31:0] PC,
    output logic        BPred,
    output logic        BPredValid
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    // Saturating increment of a 2-bit counter (stops at 2'b11).
    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'd1;
    endfunction

    // Saturating decrement of a 2-bit counter (stops at 2'b00).
    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'd1;
    endfunction

    logic [31:0]      r_pc;
    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_hit;
    logic             w_lk_taken;
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic [31:0]      w_next_pc;
    logic             w_unused_bits;

    // Instructions are word aligned; the byte-offset bits of UpdPC carry no information.
    assign w_unused_bits = ^UpdPC[1:0];

    // Lookup side: index/tag from the current fetch PC.
    assign w_lk_idx   = r_pc[IDX_W+1:2];
    assign w_lk_tag   = r_pc[31:IDX_W+2];
    assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_lk_taken = w_lk_hit && r_ctr[w_lk_idx][1];

    // Update side: index/tag from the resolved instruction's PC.
    assign w_up_idx = UpdPC[IDX_W+1:2];
    assign w_up_tag = UpdPC[31:IDX_W+2];
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    assign PC         = r_pc;
    assign BPredValid = w_lk_hit;
    assign BPred      = w_lk_taken;

    // Next-PC priority: redirect, then stall, then predicted target, then sequential.
    always_comb begin
        w_next_pc = r_pc + 32'd4;
        if (Redirect) begin
            w_next_pc = RedirectPC;
        end else if (PC_Stall) begin
            w_next_pc = r_pc;
        end else if (w_lk_taken) begin
            w_next_pc = r_target[w_lk_idx];
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    // BTB write port: train hits, allocate on taken misses, ignore not-taken misses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i[IDX_W-1:0]]  <= 1'b0;
                r_tag[i[IDX_W-1:0]]    <= '0;
                r_target[i[IDX_W-1:0]] <= '0;
                r_ctr[i[IDX_W-1:0]]    <= 2'b00;
            end
        end else if (UpdValid) begin
            if (w_up_hit) begin
                if (UpdTaken) begin
                    r_ctr[w_up_idx]    <= sat_inc(r_ctr[w_up_idx]);
                    r_target[w_up_idx] <= UpdTarget;
                end else begin
                    r_ctr[w_up_idx] <= sat_dec(r_ctr[w_up_idx]);
                end
            end else if (UpdTaken) begin
                r_valid[w_up_idx]  <= 1'b1;
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= UpdTarget;
                r_ctr[w_up_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_fetch.sv
// Directed bench for branch_predict_fetch (ENTRIES=16, RESET_PC=0).
module tb_branch_predict_fetch;

    logic        clk;
    logic        reset;
    logic        PC_Stall;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        UpdValid;
    logic [31:0] UpdPC;
    logic        UpdTaken;
    logic [31:0] UpdTarget;
    logic [31:0] PC;
    logic        BPred;
    logic        BPredValid;

    int n_checks;
    int n_fail;

    branch_predict_fetch #(
        .ENTRIES  (16),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .PC_Stall   (PC_Stall),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .UpdValid   (UpdValid),
        .UpdPC      (UpdPC),
        .UpdTaken   (UpdTaken),
        .UpdTarget  (UpdTarget),
        .PC         (PC),
        .BPred      (BPred),
        .BPredValid (BPredValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; return 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        PC_Stall   = 1'b0;
        Redirect   = 1'b0;
        RedirectPC = 32'h0;
        UpdValid   = 1'b0;
        UpdPC      = 32'h0;
        UpdTaken   = 1'b0;
        UpdTarget  = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        #12;
        n_checks++;
        if (PC !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", PC, 32'h0); end
        n_checks++;
        if (BPredValid !== 1'b0) begin n_fail++; $display("FAIL reset_bpv got=%b exp=0", BPredValid); end
        n_checks++;
        if (BPred !== 1'b0) begin n_fail++; $display("FAIL reset_bpred got=%b exp=0", BPred); end
        reset = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            n_checks++;
            if (PC !== 32'(4 * k)) begin n_fail++; $display("FAIL seq_pc%0d got=%h exp=%h", k, PC, 32'(4 * k)); end
            n_checks++;
            if ({BPredValid, BPred} !== 2'b00) begin n_fail++; $display("FAIL seq_pred%0d got=%b exp=00", k, {BPredValid, BPred}); end
        end
    endtask

    // PC is 0xC here: allocate 0x10 -> 0x40 while fetch steps onto 0x10.
    task automatic test_alloc();
        UpdValid = 1'b1; UpdPC = 32'h10; UpdTaken = 1'b1; UpdTarget = 32'h40;
        step();
        clear_inputs();
        #1;
        n_checks++;
        if (PC !== 32'h10) begin n_fail++; $display("FAIL alloc_pc got=%h exp=%h", PC, 32'h10); end
        n_checks++;
        if ({BPredValid, BPred} !== 2'b11) begin n_fail++; $display("FAIL alloc_pred got=%b exp=11", {BPredValid, BPred}); end
        step();
        n_checks++;
        if (PC !== 32'h40) begin n_fail++; $display("FAIL alloc_target got=%h exp=%h", PC, 32'h40); end
    endtask

    task automatic test_counter();
        Redirect = 1'b1; RedirectPC = 32'h10;
        step();
        clear_inputs();
        // Stall at 0x10 and train not-taken; lookup this cycle sees pre-update counter 10.
        PC_Stall = 1'b1;
        UpdValid = 1'b1; UpdPC = 32'h10; UpdTaken = 1'b0;
        #1;
        n_checks++;
        if (BPred !== 1'b1) begin n_fail++; $display("FAIL rbw_pred got=%b exp=1", BPred); end
        step();
        n_checks++;
        if ({BPredValid, BPred} !== 2'b10) begin n_fail++; $display("FAIL ctr01_pred got=%b exp=10", {BPredValid, BPred}); end
        n_checks++;
        if (PC !== 32'h10) begin n_fail++; $display("FAIL stall_pc got=%h exp=%h", PC, 32'h10); end
        step();
        step();
        n_checks++;
        if ({BPredValid, BPred} !== 2'b10) begin n_fail++; $display("FAIL ctr00_pred got=%b exp=10", {BPredValid, BPred}); end
        clear_inputs();
        step();
        n_checks++;
        if (PC !== 32'h14) begin n_fail++; $display("FAIL nt_next got=%h exp=%h", PC, 32'h14); end
        // Counter saturated at 00: one taken update gives 01, still not-taken.
        Redirect = 1'b1; RedirectPC = 32'h10;
        UpdValid = 1'b1; UpdPC = 32'h10; UpdTaken = 1'b1; UpdTarget = 32'h40;
        step();
        Redirect = 1'b0;
        UpdValid = 1'b0;
        #1;
        n_checks++;
        if ({BPredValid, BPred} !== 2'b10) begin n_fail++; $display("FAIL ctr_low_sat got=%b exp=10", {BPredValid, BPred}); end
        // Three taken updates: 01->10->11->11, then not-taken: 10 (taken), 01 (not taken).
        PC_Stall = 1'b1;
        UpdValid = 1'b1; UpdTaken = 1'b1;
        step(); step(); step();
        UpdTaken = 1'b0;
        step();
        n_checks++;
        if (BPred !== 1'b1) begin n_fail++; $display("FAIL ctr_high_sat got=%b exp=1", BPred); end
        step();
        n_checks++;
        if (BPred !== 1'b0) begin n_fail++; $display("FAIL ctr_dec01 got=%b exp=0", BPred); end
        clear_inputs();
    endtask

    task automatic test_redirect_stall();
        Redirect = 1'b1; RedirectPC = 32'h200; PC_Stall = 1'b1;
        step();
        n_checks++;
        if (PC !== 32'h200) begin n_fail++; $display("FAIL redir_over_stall got=%h exp=%h", PC, 32'h200); end
        Redirect = 1'b0;
        step();
        n_checks++;
        if (PC !== 32'h200) begin n_fail++; $display("FAIL stall_hold got=%h exp=%h", PC, 32'h200); end
        clear_inputs();
    endtask

    // 0x10 and 0x50 share index 4 with tags 0 and 1.
    task automatic test_alias();
        Redirect = 1'b1; RedirectPC = 32'h10;
        UpdValid = 1'b1; UpdPC = 32'h50; UpdTaken = 1'b1; UpdTarget = 32'h80;
        step();
        UpdValid = 1'b0;
        #1;
        n_checks++;
        if ({BPredValid, BPred} !== 2'b00) begin n_fail++; $display("FAIL alias_old_miss got=%b exp=00", {BPredValid, BPred}); end
        RedirectPC = 32'h50;
        step();
        Redirect = 1'b0;
        #1;
        n_checks++;
        if ({BPredValid, BPred} !== 2'b11) begin n_fail++; $display("FAIL alias_new_hit got=%b exp=11", {BPredValid, BPred}); end
        step();
        n_checks++;
        if (PC !== 32'h80) begin n_fail++; $display("FAIL alias_target got=%h exp=%h", PC, 32'h80); end
        clear_inputs();
    endtask

    task automatic test_wrap();
        Redirect = 1'b1; RedirectPC = 32'hFFFF_FFFC;
        step();
        Redirect = 1'b0;
        #1;
        n_checks++;
        if (BPredValid !== 1'b0) begin n_fail++; $display("FAIL wrap_bpv got=%b exp=0", BPredValid); end
        step();
        n_checks++;
        if (PC !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got=%h exp=%h", PC, 32'h0); end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        Redirect = 1'b1; RedirectPC = 32'h84;
        UpdValid = 1'b1; UpdPC = 32'h84; UpdTaken = 1'b1; UpdTarget = 32'h100;
        step();
        Redirect = 1'b0;
        // In-flight update that reset must discard.
        UpdPC = 32'h88; UpdTarget = 32'h300;
        #1;
        n_checks++;
        if ({BPredValid, BPred} !== 2'b11) begin n_fail++; $display("FAIL pre_rst_hit got=%b exp=11", {BPredValid, BPred}); end
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (PC !== 32'h0) begin n_fail++; $display("FAIL rst_async_pc got=%h exp=%h", PC, 32'h0); end
        n_checks++;
        if ({BPredValid, BPred} !== 2'b00) begin n_fail++; $display("FAIL rst_async_pred got=%b exp=00", {BPredValid, BPred}); end
        step();
        #2;
        reset = 1'b1;
        clear_inputs();
        #1;
        n_checks++;
        if (PC !== 32'h0) begin n_fail++; $display("FAIL rst_release_pc got=%h exp=%h", PC, 32'h0); end
        step();
        n_checks++;
        if (PC !== 32'h4) begin n_fail++; $display("FAIL rst_first_fetch got=%h exp=%h", PC, 32'h4); end
        Redirect = 1'b1; RedirectPC = 32'h84;
        step();
        n_checks++;
        if (BPredValid !== 1'b0) begin n_fail++; $display("FAIL rst_miss_84 got=%b exp=0", BPredValid); end
        RedirectPC = 32'h50;
        step();
        n_checks++;
        if (BPredValid !== 1'b0) begin n_fail++; $display("FAIL rst_miss_50 got=%b exp=0", BPredValid); end
        RedirectPC = 32'h88;
        step();
        n_checks++;
        if (BPredValid !== 1'b0) begin n_fail++; $display("FAIL rst_miss_88 got=%b exp=0", BPredValid); end
        clear_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_alloc();
        test_counter();
        test_redirect_stall();
        test_alias();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
